// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encoding, opcodes,
// ALU control encodings and the decoded-control bundle.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4
  } seqState_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_TST = 3'd7;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_XOR   = 2'b10;
  localparam logic [1:0] ALU_SHIFT = 2'b11;

  typedef struct packed {
    logic [1:0] aluOp;
    logic       subShiftDir;
    logic       writeback;
  } aluCtrl_t;

endpackage

// File: rtl/alu_sequencer_decode.sv
// Pure combinational opcode decode; kept standalone so trace/disassembly
// tooling can share the exact same mapping as the sequencer.
module alu_op_decode
  import alu_sequencer_pkg::*;
(
  input  logic [2:0] op_i,
  output aluCtrl_t   ctrl_o
);

  // CMP and TST reuse SUB and AND datapaths but only feed the flags.
  always_comb begin
    ctrl_o = '{aluOp: ALU_ADD, subShiftDir: 1'b0, writeback: 1'b1};
    case (op_i)
      OP_ADD:  ctrl_o = '{aluOp: ALU_ADD,   subShiftDir: 1'b0, writeback: 1'b1};
      OP_SUB:  ctrl_o = '{aluOp: ALU_ADD,   subShiftDir: 1'b1, writeback: 1'b1};
      OP_AND:  ctrl_o = '{aluOp: ALU_AND,   subShiftDir: 1'b0, writeback: 1'b1};
      OP_XOR:  ctrl_o = '{aluOp: ALU_XOR,   subShiftDir: 1'b0, writeback: 1'b1};
      OP_SHR:  ctrl_o = '{aluOp: ALU_SHIFT, subShiftDir: 1'b0, writeback: 1'b1};
      OP_SHL:  ctrl_o = '{aluOp: ALU_SHIFT, subShiftDir: 1'b1, writeback: 1'b1};
      OP_CMP:  ctrl_o = '{aluOp: ALU_ADD,   subShiftDir: 1'b1, writeback: 1'b0};
      OP_TST:  ctrl_o = '{aluOp: ALU_AND,   subShiftDir: 1'b0, writeback: 1'b0};
      default: ctrl_o = '{aluOp: ALU_ADD,   subShiftDir: 1'b0, writeback: 1'b1};
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Four-phase sequencer driving the shared 8-bit bus, register file strobes and
// ALU controls for one instruction at a time, plus the N/Z flag register.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_instrValid,
  output logic       o_instrReady,
  input  logic [2:0] i_op,
  input  logic       i_immSel,
  input  logic [2:0] i_rd,
  input  logic [2:0] i_rs1,
  input  logic [2:0] i_rs2,
  input  logic [7:0] i_imm,
  output logic [2:0] o_rfRdAddr,
  output logic       o_rfRdOe,
  output logic       o_immOe,
  output logic [7:0] o_imm,
  output logic       o_aWr,
  output logic       o_bWr,
  output logic [1:0] o_aluOp,
  output logic       o_subShiftDir,
  output logic       o_aluWr,
  output logic       o_aluNoe,
  output logic [2:0] o_rfWrAddr,
  output logic       o_rfWr,
  input  logic       i_negative,
  input  logic       i_nZero,
  output logic       o_flagN,
  output logic       o_flagZ,
  output logic       o_busy
);

  seqState_e  state_q, state_d;
  logic [2:0] op_q, rd_q, rs1_q, rs2_q;
  logic       immSel_q;
  logic [7:0] imm_q;
  logic       flagN_q, flagZ_q;
  logic       accept;
  aluCtrl_t   ctrl;

  alu_op_decode uDecode (
    .op_i   (op_q),
    .ctrl_o (ctrl)
  );

  // WRITE also accepts so a held valid sustains one instruction per 4 cycles.
  assign o_instrReady = (state_q == IDLE) || (state_q == WRITE);
  assign accept       = i_instrValid && o_instrReady;

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD_A;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = accept ? LOAD_A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore strobes: bus drivers are mutually exclusive by construction.
  always_comb begin
    o_rfRdAddr = rs1_q;
    o_rfRdOe   = 1'b0;
    o_immOe    = 1'b0;
    o_aWr      = 1'b0;
    o_bWr      = 1'b0;
    o_aluWr    = 1'b0;
    o_aluNoe   = 1'b1;
    o_rfWr     = 1'b0;
    case (state_q)
      LOAD_A: begin
        o_rfRdOe = 1'b1;
        o_aWr    = 1'b1;
      end
      LOAD_B: begin
        o_bWr = 1'b1;
        if (immSel_q) begin
          o_immOe = 1'b1;
        end else begin
          o_rfRdAddr = rs2_q;
          o_rfRdOe   = 1'b1;
        end
      end
      EXEC:  o_aluWr = 1'b1;
      WRITE: begin
        if (ctrl.writeback) begin
          o_aluNoe = 1'b0;
          o_rfWr   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      op_q     <= '0;
      immSel_q <= 1'b0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
    end else if (accept) begin
      op_q     <= i_op;
      immSel_q <= i_immSel;
      rd_q     <= i_rd;
      rs1_q    <= i_rs1;
      rs2_q    <= i_rs2;
      imm_q    <= i_imm;
    end
  end

  // Flags follow the ALU status only at the close of WRITE, writeback or not.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      flagN_q <= 1'b0;
      flagZ_q <= 1'b0;
    end else if (state_q == WRITE) begin
      flagN_q <= i_negative;
      flagZ_q <= ~i_nZero;
    end
  end

  assign o_imm         = imm_q;
  assign o_aluOp       = ctrl.aluOp;
  assign o_subShiftDir = ctrl.subShiftDir;
  assign o_rfWrAddr    = rd_q;
  assign o_flagN       = flagN_q;
  assign o_flagZ       = flagZ_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small register file and ALU model
// hanging off the strobes, so bus values and flags come from real operands.
module tb_alu_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_instrValid;
  logic       o_instrReady;
  logic [2:0] i_op;
  logic       i_immSel;
  logic [2:0] i_rd, i_rs1, i_rs2;
  logic [7:0] i_imm;
  logic [2:0] o_rfRdAddr;
  logic       o_rfRdOe, o_immOe;
  logic [7:0] o_imm;
  logic       o_aWr, o_bWr;
  logic [1:0] o_aluOp;
  logic       o_subShiftDir, o_aluWr, o_aluNoe;
  logic [2:0] o_rfWrAddr;
  logic       o_rfWr;
  logic       i_negative, i_nZero;
  logic       o_flagN, o_flagZ, o_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rf [8];
  logic [7:0] aReg, bReg, aluRes, bus;
  int         rfWrCount = 0;
  int         wrSnapshot;

  alu_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_instrValid(i_instrValid), .o_instrReady(o_instrReady),
    .i_op(i_op), .i_immSel(i_immSel), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_imm(i_imm), .o_rfRdAddr(o_rfRdAddr), .o_rfRdOe(o_rfRdOe), .o_immOe(o_immOe),
    .o_imm(o_imm), .o_aWr(o_aWr), .o_bWr(o_bWr), .o_aluOp(o_aluOp),
    .o_subShiftDir(o_subShiftDir), .o_aluWr(o_aluWr), .o_aluNoe(o_aluNoe),
    .o_rfWrAddr(o_rfWrAddr), .o_rfWr(o_rfWr), .i_negative(i_negative),
    .i_nZero(i_nZero), .o_flagN(o_flagN), .o_flagZ(o_flagZ), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] aluCalc(input logic [1:0] op, input logic dir,
                                         input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return dir ? (a - b) : (a + b);
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return dir ? (a << b[2:0]) : (a >> b[2:0]);
    endcase
  endfunction

  always_comb begin
    bus = 8'hEE;
    if (o_rfRdOe)       bus = rf[o_rfRdAddr];
    else if (o_immOe)   bus = o_imm;
    else if (!o_aluNoe) bus = aluRes;
  end

  assign i_negative = aluRes[7];
  assign i_nZero    = |aluRes;

  // Register file preset on reset: r1=05 r2=0A r5=03 r6=01 r7=02.
  always @(posedge i_clk) begin
    if (o_aWr)   aReg   <= bus;
    if (o_bWr)   bReg   <= bus;
    if (o_aluWr) aluRes <= aluCalc(o_aluOp, o_subShiftDir, aReg, bReg);
    if (i_reset)     rf <= '{8'h00, 8'h05, 8'h0A, 8'h00, 8'h00, 8'h03, 8'h01, 8'h02};
    else if (o_rfWr) rf[o_rfWrAddr] <= bus;
    if (o_rfWr) rfWrCount <= rfWrCount + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents an instruction and returns just after the edge that accepts it.
  task automatic applyStimulus(input logic [2:0] op, input logic immSel, input logic [2:0] rd,
                               input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm);
    int waitCycles = 0;
    i_op = op; i_immSel = immSel; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
    i_instrValid = 1'b1;
    while (!o_instrReady && waitCycles < 8) begin
      tick();
      waitCycles++;
    end
    checkOutput("readyBeforeAccept", {31'd0, o_instrReady}, 32'd1);
    tick();
  endtask

  initial begin
    i_reset = 1'b1;
    i_instrValid = 1'b1;
    i_op = 3'd0; i_immSel = 1'b0; i_rd = 3'd3; i_rs1 = 3'd1; i_rs2 = 3'd2; i_imm = 8'h55;
    tick();
    tick();
    checkOutput("rstBusy",   {31'd0, o_busy}, 32'd0);
    checkOutput("rstFlags",  {30'd0, o_flagN, o_flagZ}, 32'd0);
    checkOutput("rstStrobe", {26'd0, o_rfRdOe, o_immOe, o_aWr, o_bWr, o_aluWr, o_rfWr}, 32'd0);
    checkOutput("rstNoe",    {31'd0, o_aluNoe}, 32'd1);
    checkOutput("rstFields", {21'd0, o_rfWrAddr, o_imm}, 32'd0);
    checkOutput("rstReady",  {31'd0, o_instrReady}, 32'd1);
    i_reset = 1'b0;
    i_instrValid = 1'b0;
    tick();
    checkOutput("noAcceptInReset", {31'd0, o_busy}, 32'd0);

    $display("[TB] ADD r3 = r1 + r2");
    applyStimulus(3'd0, 1'b0, 3'd3, 3'd1, 3'd2, 8'h00);
    i_instrValid = 1'b0;
    checkOutput("addC1Addr", {29'd0, o_rfRdAddr}, 32'd1);
    checkOutput("addC1Strb", {29'd0, o_rfRdOe, o_aWr, o_busy}, 32'b111);
    checkOutput("addC1Ready", {31'd0, o_instrReady}, 32'd0);
    tick();
    checkOutput("addC2Addr", {29'd0, o_rfRdAddr}, 32'd2);
    checkOutput("addC2Strb", {28'd0, o_rfRdOe, o_immOe, o_bWr, o_aWr}, 32'b1010);
    tick();
    checkOutput("addC3AluWr", {30'd0, o_aluWr, o_rfWr}, 32'b10);
    tick();
    checkOutput("addC4Wr",  {28'd0, o_rfWr, o_aluNoe, o_instrReady, o_busy}, 32'b1011);
    checkOutput("addC4Addr", {29'd0, o_rfWrAddr}, 32'd3);
    checkOutput("addC4Bus", {24'd0, bus}, 32'h0F);
    tick();
    checkOutput("addFlags", {30'd0, o_flagN, o_flagZ}, 32'b00);
    checkOutput("addRf3",   {24'd0, rf[3]}, 32'h0F);
    checkOutput("addIdle",  {31'd0, o_busy}, 32'd0);

    $display("[TB] SUB r4 = r5 - imm 03");
    applyStimulus(3'd1, 1'b1, 3'd4, 3'd5, 3'd6, 8'h03);
    i_instrValid = 1'b0;
    checkOutput("subC1Addr", {29'd0, o_rfRdAddr}, 32'd5);
    checkOutput("subCtl", {29'd0, o_aluOp, o_subShiftDir}, 32'b001);
    tick();
    checkOutput("subC2Oe",  {30'd0, o_immOe, o_rfRdOe}, 32'b10);
    checkOutput("subC2Imm", {24'd0, o_imm}, 32'h03);
    checkOutput("subC2Bus", {24'd0, bus}, 32'h03);
    tick();
    tick();
    checkOutput("subC4Bus", {24'd0, bus}, 32'h00);
    tick();
    checkOutput("subFlags", {30'd0, o_flagN, o_flagZ}, 32'b01);
    checkOutput("subRf4",   {24'd0, rf[4]}, 32'h00);

    $display("[TB] CMP r6 vs r7");
    wrSnapshot = rfWrCount;
    applyStimulus(3'd6, 1'b0, 3'd2, 3'd6, 3'd7, 8'h00);
    i_instrValid = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("cmpC4NoWr", {30'd0, o_rfWr, o_aluNoe}, 32'b01);
    checkOutput("cmpResult", {24'd0, aluRes}, 32'hFF);
    tick();
    checkOutput("cmpFlags", {30'd0, o_flagN, o_flagZ}, 32'b10);
    checkOutput("cmpNoWrite", rfWrCount - wrSnapshot, 32'd0);
    checkOutput("cmpRf2", {24'd0, rf[2]}, 32'h0A);

    $display("[TB] back-to-back SHL r3 = r6 << r7, XOR r4 = r1 ^ r2");
    applyStimulus(3'd5, 1'b0, 3'd3, 3'd6, 3'd7, 8'h00);
    i_op = 3'd3; i_rd = 3'd4; i_rs1 = 3'd1; i_rs2 = 3'd2;
    checkOutput("shlC1Addr",  {29'd0, o_rfRdAddr}, 32'd6);
    checkOutput("shlC1Ready", {31'd0, o_instrReady}, 32'd0);
    checkOutput("shlCtl", {29'd0, o_aluOp, o_subShiftDir}, 32'b111);
    tick();
    checkOutput("shlC2Addr",  {29'd0, o_rfRdAddr}, 32'd7);
    checkOutput("shlC2Ready", {31'd0, o_instrReady}, 32'd0);
    tick();
    checkOutput("shlC3Ready", {31'd0, o_instrReady}, 32'd0);
    checkOutput("shlC3Busy",  {31'd0, o_busy}, 32'd1);
    tick();
    checkOutput("shlC4Ready", {31'd0, o_instrReady}, 32'd1);
    checkOutput("shlC4Addr",  {29'd0, o_rfWrAddr}, 32'd3);
    checkOutput("shlC4Bus",   {24'd0, bus}, 32'h04);
    tick();
    i_instrValid = 1'b0;
    checkOutput("xorC5LoadA", {28'd0, o_rfRdAddr, o_aWr}, {28'd0, 3'd1, 1'b1});
    checkOutput("xorC5Busy",  {31'd0, o_busy}, 32'd1);
    checkOutput("shlFlags",   {30'd0, o_flagN, o_flagZ}, 32'b00);
    checkOutput("shlRf3",     {24'd0, rf[3]}, 32'h04);
    for (int c = 6; c <= 8; c++) begin
      tick();
      checkOutput("xorBusy", {31'd0, o_busy}, 32'd1);
    end
    checkOutput("xorC8Bus",  {24'd0, bus}, 32'h0F);
    checkOutput("xorC8Addr", {29'd0, o_rfWrAddr}, 32'd4);
    checkOutput("xorCtl", {29'd0, o_aluOp, o_subShiftDir}, 32'b100);
    tick();
    checkOutput("xorRf4", {24'd0, rf[4]}, 32'h0F);
    checkOutput("xorIdle", {31'd0, o_busy}, 32'd0);

    $display("[TB] reset during EXEC of SUB r5 = r1 - r2");
    wrSnapshot = rfWrCount;
    applyStimulus(3'd1, 1'b0, 3'd5, 3'd1, 3'd2, 8'h00);
    i_instrValid = 1'b0;
    tick();
    tick();
    checkOutput("rstMidExec", {31'd0, o_aluWr}, 32'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checkOutput("rstMidBusy",  {31'd0, o_busy}, 32'd0);
    checkOutput("rstMidFlags", {30'd0, o_flagN, o_flagZ}, 32'b00);
    checkOutput("rstMidNoe",   {31'd0, o_aluNoe}, 32'd1);
    tick();
    tick();
    checkOutput("rstMidFlagsLater", {30'd0, o_flagN, o_flagZ}, 32'b00);
    checkOutput("rstMidNoWrite", rfWrCount - wrSnapshot, 32'd0);
    checkOutput("rstMidReady", {31'd0, o_instrReady}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
